// File: rtl/wide_add_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package wide_add_pkg;

  // Width of the single time-multiplexed adder slice
  localparam int unsigned SLICE_W = 8;

  // in_sub encodings
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add8_slice.sv
// Combinational 8-bit ripple-carry adder slice.
module add8_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic w_carry;

  // Ripple the carry bit by bit, LSB first
  always_comb begin
    w_carry = cin;
    sum     = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i]  = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
    cout = w_carry;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built from one 8-bit slice, one byte per cycle, LSB first.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter  int unsigned NUM_SLICES = 4,
  localparam int unsigned IDX_W      = $clog2(NUM_SLICES),
  localparam int unsigned W          = SLICE_W * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy
);

  state_e r_state;
  state_e w_state_next;

  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_cout;

  logic               w_accept;
  logic               w_last;
  logic               w_run;
  logic [SLICE_W-1:0] w_a_byte;
  logic [SLICE_W-1:0] w_b_byte;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  assign w_run    = (r_state == RUN);
  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == IDX_W'(NUM_SLICES - 1));
  assign w_a_byte = r_a[SLICE_W*r_idx +: SLICE_W];
  assign w_b_byte = r_b[SLICE_W*r_idx +: SLICE_W];

  add8_slice u_slice (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode, from the state register only
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // A same-cycle in_valid is not seen until the following IDLE cycle
        if (out_ready) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        busy         = 1'b0;
      end
    endcase
  end

  // Operand capture; subtract is folded into A + ~B + 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= in_a;
      r_b <= (in_sub == OP_SUB) ? ~in_b : in_b;
    end
  end

  // Slice index and inter-byte carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= (in_sub == OP_ADD) ? in_cin : 1'b1;
    end else if (w_run) begin
      r_carry <= w_slice_cout;
      r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Result bytes and final carry; held until the next operation overwrites them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_run) begin
      r_sum[SLICE_W*r_idx +: SLICE_W] <= w_slice_sum;
      if (w_last) r_cout <= w_slice_cout;
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_cout;

endmodule
